// File: rtl/pc_unit.sv
// Fetch-stage program counter: start/stall gating, trap and redirect priority, circular RAS.
// Optional alignment check of redirect/return targets enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'h0000_0100),
  parameter int              INC       = 4,
  parameter int              RAS_DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic                         stall_i,
  input  logic                         redirect_i,
  input  logic [PC_W-1:0]              redirect_pc_i,
  input  logic                         call_i,
  input  logic                         ret_i,
  input  logic                         trap_i,
  output logic [PC_W-1:0]              pc_o,
  output logic                         pc_valid_o,
  output logic [$clog2(RAS_DEPTH):0]   ras_count_o,
  output logic                         ret_miss_o,
  output logic                         misalign_o
);

  localparam int              PTR_W = $clog2(RAS_DEPTH);
  localparam int              CNT_W = PTR_W + 1;
  localparam logic [PC_W-1:0] INC_V = PC_W'(INC);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(RAS_DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state, w_state_next;
  logic [PC_W-1:0]    r_pc, w_pc_next, w_pc_inc, w_target, w_top;
  logic [PC_W-1:0]    r_ras [RAS_DEPTH];
  logic [PTR_W-1:0]   r_ptr, w_ptr_dec;
  logic [CNT_W-1:0]   r_count;
  logic               r_miss, w_miss;
  logic               w_run, w_push, w_replace, w_pop, w_load, w_misalign;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start_i)  w_state_next = RUN;
      RUN:     if (!start_i) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pc_valid_o = (r_state == RUN);
  end

  assign w_run     = (r_state == RUN) && start_i;
  assign w_pc_inc  = r_pc + INC_V;
  assign w_ptr_dec = r_ptr - PTR_W'(1);
  assign w_top     = r_ras[w_ptr_dec];

  // Next-PC priority: trap, stall, redirect (call / call+ret / ret), ret, sequential.
  always_comb begin
    w_target  = redirect_pc_i;
    w_load    = 1'b0;
    w_push    = 1'b0;
    w_replace = 1'b0;
    w_pop     = 1'b0;
    w_miss    = 1'b0;
    w_pc_next = r_pc;
    if (w_run) begin
      if (trap_i) begin
        w_pc_next = TRAP_VEC;
      end else if (stall_i) begin
        w_pc_next = r_pc;
      end else if (redirect_i) begin
        w_load = 1'b1;
        if (call_i && (!ret_i || r_count == '0)) w_push = 1'b1;
        else if (call_i)                         w_replace = 1'b1;
        else if (ret_i && r_count != '0)         w_pop = 1'b1;
      end else if (ret_i && r_count != '0) begin
        w_target = w_top;
        w_load   = 1'b1;
        w_pop    = 1'b1;
      end else begin
        w_pc_next = w_pc_inc;
        w_miss    = ret_i;
      end
      if (w_load) w_pc_next = w_misalign ? TRAP_VEC : w_target;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  localparam logic [PC_W-1:0] ALIGN_MASK = PC_W'(INC - 1);
  logic r_misalign;

  assign w_misalign = w_load && ((w_target & ALIGN_MASK) != '0);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_misalign <= 1'b0;
    else        r_misalign <= w_misalign;
  end
  assign misalign_o = r_misalign;
`else
  assign w_misalign = 1'b0;
  assign misalign_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc    <= RESET_VEC;
      r_ptr   <= '0;
      r_count <= '0;
      r_miss  <= 1'b0;
    end else begin
      r_pc   <= w_pc_next;
      r_miss <= w_miss;
      if (w_push) begin
        r_ptr <= r_ptr + PTR_W'(1);
        if (r_count != FULL) r_count <= r_count + CNT_W'(1);
      end else if (w_pop) begin
        r_ptr   <= w_ptr_dec;
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Stack contents need no reset; full pushes overwrite the oldest slot naturally.
  always_ff @(posedge clk_i) begin
    if (w_push)         r_ras[r_ptr]     <= w_pc_inc;
    else if (w_replace) r_ras[w_ptr_dec] <= w_pc_inc;
  end

  assign pc_o        = r_pc;
  assign ras_count_o = r_count;
  assign ret_miss_o  = r_miss;

endmodule

// File: tb/tb_pc_unit.sv
// Directed table-driven bench for pc_unit with hand sequences for wrap, stop, reset and alignment.
module tb_pc_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i, stall_i, redirect_i, call_i, ret_i, trap_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] pc_o;
  logic        pc_valid_o, ret_miss_o, misalign_o;
  logic [2:0]  ras_count_o;

  int checks = 0;
  int errors = 0;

  pc_unit dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .call_i(call_i),
    .ret_i(ret_i), .trap_i(trap_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
    .ras_count_o(ras_count_o), .ret_miss_o(ret_miss_o), .misalign_o(misalign_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st, sl, rd, cl, rt, tp;
    logic [31:0] rpc;
    logic [31:0] epc;
    logic        ev;
    logic [2:0]  ecnt;
    logic        emiss;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic st, sl, rd, cl, rt, tp, input logic [31:0] rpc,
                     input logic [31:0] epc, input logic ev, input logic [2:0] ecnt,
                     input logic emiss);
    vec_t v;
    v.st = st; v.sl = sl; v.rd = rd; v.cl = cl; v.rt = rt; v.tp = tp; v.rpc = rpc;
    v.epc = epc; v.ev = ev; v.ecnt = ecnt; v.emiss = emiss;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, sl, rd, cl, rt, tp, input logic [31:0] rpc);
    start_i = st; stall_i = sl; redirect_i = rd; call_i = cl; ret_i = rt; trap_i = tp;
    redirect_pc_i = rpc;
  endtask

  task automatic step(input logic st, sl, rd, cl, rt, tp, input logic [31:0] rpc);
    drive(st, sl, rd, cl, rt, tp, rpc);
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [31:0] epc, input logic ev,
                           input logic [2:0] ecnt, input logic emiss, input logic emis);
    check({tag, ".pc"}, pc_o, epc);
    check({tag, ".valid"}, {31'b0, pc_valid_o}, {31'b0, ev});
    check({tag, ".count"}, {29'b0, ras_count_o}, {29'b0, ecnt});
    check({tag, ".miss"}, {31'b0, ret_miss_o}, {31'b0, emiss});
    check({tag, ".misalign"}, {31'b0, misalign_o}, {31'b0, emis});
    $display("step %s: pc=0x%08h valid=%0b cnt=%0d miss=%0b mis=%0b", tag, pc_o,
             pc_valid_o, ras_count_o, ret_miss_o, misalign_o);
  endtask

  initial begin
    // Test 1: idle then start
    for (int i = 0; i < 5; i++) add(0,0,0,0,0,0, 32'h0,   32'h0,   0, 0, 0);
    add(1,0,0,0,0,0, 32'h0,   32'h0,   1, 0, 0);
    add(1,0,0,0,0,0, 32'h0,   32'h4,   1, 0, 0);
    add(1,0,0,0,0,0, 32'h0,   32'h8,   1, 0, 0);
    add(1,0,0,0,0,0, 32'h0,   32'hC,   1, 0, 0);
    add(1,0,0,0,0,0, 32'h0,   32'h10,  1, 0, 0);
    // Test 2: stall beats redirect, trap beats stall
    for (int i = 0; i < 3; i++) add(1,1,1,0,0,0, 32'h300, 32'h10, 1, 0, 0);
    add(1,0,0,0,0,0, 32'h0,   32'h14,  1, 0, 0);
    add(1,1,0,0,0,1, 32'h0,   32'h100, 1, 0, 0);
    // Test 3: call and return
    add(1,0,1,0,0,0, 32'h20,  32'h20,  1, 0, 0);
    add(1,0,1,1,0,0, 32'h200, 32'h200, 1, 1, 0);
    add(1,0,0,0,1,0, 32'h0,   32'h24,  1, 0, 0);
    // Test 4: overflowing RAS then draining
    add(1,0,1,0,0,0, 32'h0,   32'h0,   1, 0, 0);
    add(1,0,1,1,0,0, 32'h8,   32'h8,   1, 1, 0);
    add(1,0,1,1,0,0, 32'h10,  32'h10,  1, 2, 0);
    add(1,0,1,1,0,0, 32'h18,  32'h18,  1, 3, 0);
    add(1,0,1,1,0,0, 32'h20,  32'h20,  1, 4, 0);
    add(1,0,1,1,0,0, 32'h40,  32'h40,  1, 4, 0);
    add(1,0,0,0,1,0, 32'h0,   32'h24,  1, 3, 0);
    add(1,0,0,0,1,0, 32'h0,   32'h1C,  1, 2, 0);
    add(1,0,0,0,1,0, 32'h0,   32'h14,  1, 1, 0);
    add(1,0,0,0,1,0, 32'h0,   32'hC,   1, 0, 0);
    add(1,0,0,0,1,0, 32'h0,   32'h10,  1, 0, 1);
    add(1,0,0,0,0,0, 32'h0,   32'h14,  1, 0, 0);
    // call+ret combinations
    add(1,0,1,1,1,0, 32'h80,  32'h80,  1, 1, 0);  // empty: plain push of 0x18
    add(1,0,1,1,1,0, 32'h90,  32'h90,  1, 1, 0);  // replace top with 0x84
    add(1,0,0,0,1,0, 32'h0,   32'h84,  1, 0, 0);
    add(1,0,1,0,1,0, 32'hA0,  32'hA0,  1, 0, 0);  // pop on empty stays at 0
    add(1,0,1,1,0,0, 32'hB0,  32'hB0,  1, 1, 0);
    add(1,0,1,0,1,0, 32'hC0,  32'hC0,  1, 0, 0);  // pop discards 0xA4
    add(1,0,0,0,1,0, 32'h0,   32'hC4,  1, 0, 1);
    add(1,0,0,1,0,0, 32'hE0,  32'hC8,  1, 0, 0);  // call without redirect ignored

    drive(0,0,0,0,0,0, 32'h0);
    #2;
    check_all("reset", 32'h0, 0, 0, 0, 0);
    #10 rst_i = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].sl, vecs[i].rd, vecs[i].cl, vecs[i].rt, vecs[i].tp, vecs[i].rpc);
      check_all($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ev, vecs[i].ecnt, vecs[i].emiss, 1'b0);
    end

    // Test 5: wrap, stop/hold, restart, async reset
    step(1,0,1,0,0,0, 32'hFFFF_FFFC); check_all("wrap_load", 32'hFFFF_FFFC, 1, 0, 0, 0);
    step(1,0,0,0,0,0, 32'h0);         check_all("wrap",      32'h0, 1, 0, 0, 0);
    step(1,0,0,0,0,0, 32'h0);         check_all("post_wrap", 32'h4, 1, 0, 0, 0);
    step(0,0,0,0,0,0, 32'h0);         check_all("stop",      32'h4, 0, 0, 0, 0);
    step(0,0,1,1,0,1, 32'h500);       check_all("idle_ign",  32'h4, 0, 0, 0, 0);
    step(1,0,0,0,0,0, 32'h0);         check_all("restart",   32'h4, 1, 0, 0, 0);
    step(1,0,1,1,0,0, 32'h600);       check_all("pre_rst",   32'h600, 1, 1, 0, 0);
    #3 rst_i = 1'b0;
    #1 check_all("async_rst", 32'h0, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    step(1,0,0,0,0,0, 32'h0);         check_all("rst_start", 32'h0, 1, 0, 0, 0);
    step(1,0,0,0,0,0, 32'h0);         check_all("rst_run",   32'h4, 1, 0, 0, 0);

    // Test 6: misaligned redirect target
`ifdef PC_ALIGN_CHECK_EN
    step(1,0,1,0,0,0, 32'h202);       check_all("misalign",   32'h100, 1, 0, 0, 1);
    step(1,0,0,0,0,0, 32'h0);         check_all("misalign_e", 32'h104, 1, 0, 0, 0);
`else
    step(1,0,1,0,0,0, 32'h202);       check_all("misalign",   32'h202, 1, 0, 0, 0);
    step(1,0,0,0,0,0, 32'h0);         check_all("misalign_e", 32'h206, 1, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
